// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked load/store responder over a word-organised RAM
//
// Accepts one load/store request at a time (req_valid/req_ready), performs a
// byte/half/word access on an internal little-endian RAM after WAIT_CYCLES
// wait states, and returns the sign/zero-extended result (rsp_valid/rsp_ready).
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   req_valid    request present
//   req_ready    responder can accept a request (registered)
//   req_addr     byte address
//   req_we       1 = store, 0 = load
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned loads only: 1 = zero-extend, 0 = sign-extend
//   req_wdata    store data, right-aligned
//   rsp_valid    response present (registered)
//   rsp_ready    initiator accepts the response
//   rsp_rdata    load result; 0 for stores and faults
//   rsp_err      access fault on this response
//   leds         6-bit LED register; 0 unless DMEM_LED_MMIO_EN is defined
//
// Optional feature macro: DMEM_LED_MMIO_EN (word-only LED register at LED_ADDR).

module dmem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] LED_ADDR    = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  leds
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] lat_addr;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    // The access operand set comes straight from the request port when the
    // access happens on the accept edge (WAIT_CYCLES == 0), otherwise from
    // the latched copy, so later input changes cannot leak in.
    logic [31:0] acc_addr;
    logic        acc_we;
    logic [1:0]  acc_size;
    logic        acc_unsigned;
    logic [31:0] acc_wdata;

    logic [31:0] offset;
    logic [AW-1:0] word_idx;
    logic        misalign;
    logic        out_of_range;
    logic        fault;
    logic        is_led;
    logic        do_access;
    logic [31:0] ram_word;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] rdata_nxt;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lane;
    logic [31:0] merged;

    always_comb begin
        if (state == S_IDLE) begin
            acc_addr     = req_addr;
            acc_we       = req_we;
            acc_size     = req_size;
            acc_unsigned = req_unsigned;
            acc_wdata    = req_wdata;
        end else begin
            acc_addr     = lat_addr;
            acc_we       = lat_we;
            acc_size     = lat_size;
            acc_unsigned = lat_unsigned;
            acc_wdata    = lat_wdata;
        end

        // Wrapping subtraction: addresses below ADDR_BASE become huge offsets.
        offset       = acc_addr - ADDR_BASE;
        word_idx     = offset[AW+1:2];
        misalign     = (acc_size == 2'b11) ||
                       (acc_size == 2'b01 && acc_addr[0]) ||
                       (acc_size == 2'b10 && acc_addr[1:0] != 2'b00);
        out_of_range = (offset >= RAM_BYTES);
`ifdef DMEM_LED_MMIO_EN
        is_led = (acc_addr == LED_ADDR);
        fault  = is_led ? (acc_size != 2'b10) : (misalign || out_of_range);
`else
        is_led = 1'b0;
        fault  = misalign || out_of_range;
`endif

        ram_word = mem[word_idx];
        shifted  = ram_word >> {offset[1:0], 3'b000};
        case (acc_size)
            2'b00:   load_data = acc_unsigned ? {24'h0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = acc_unsigned ? {16'h0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = ram_word;
        endcase

        if (fault || acc_we)
            rdata_nxt = 32'h0;
        else if (is_led)
            rdata_nxt = {26'h0, leds};
        else
            rdata_nxt = load_data;

        // Halves are aligned, so shifting by the byte lane also places them.
        case (acc_size)
            2'b00:   byte_en = 4'b0001 << offset[1:0];
            2'b01:   byte_en = 4'b0011 << offset[1:0];
            default: byte_en = 4'b1111;
        endcase
        wdata_lane = acc_wdata << {offset[1:0], 3'b000};
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = byte_en[i] ? wdata_lane[8*i +: 8] : ram_word[8*i +: 8];

        // The access executes on the edge that enters RESP.
        do_access = ((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                    ((state == S_WAIT) && (cnt == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (!rst && do_access && acc_we && !fault && !is_led)
            mem[word_idx] <= merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            cnt       <= 4'd0;
`ifdef DMEM_LED_MMIO_EN
            leds      <= 6'h0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_addr     <= req_addr;
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_wdata    <= req_wdata;
                        req_ready    <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0)
                        state <= S_RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase

            if (do_access) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rdata_nxt;
                rsp_err   <= fault;
`ifdef DMEM_LED_MMIO_EN
                if (is_led && acc_we && !fault)
                    leds <= acc_wdata[5:0];
`endif
            end
        end
    end

`ifndef DMEM_LED_MMIO_EN
    assign leds = 6'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder

module tb_dmem_responder;

    localparam int WAITC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  leds;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .leds(leds)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] er;
        logic        ee;
    } op_t;

    int errors = 0;
    int checks = 0;
    logic [32:0] sb [$];

    // Drives one request and collects its response. Expected {err, rdata} is
    // pushed to the scoreboard here; callers pop and compare.
    task automatic do_req(input op_t op, input int hold,
                          output logic [31:0] r, output logic e,
                          output int lat, output bit stab, output bit ok);
        int n;
        sb.push_back({op.ee, op.er});
        rsp_ready    = (hold == 0);
        req_valid    = 1'b1;
        req_addr     = op.addr;
        req_we       = op.we;
        req_size     = op.size;
        req_unsigned = op.uns;
        req_wdata    = op.wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        ok = 0; stab = 0; r = 32'hx; e = 1'bx; lat = 0;
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble inputs after accept; the responder must ignore them.
        req_valid    = 1'b0;
        req_addr     = $urandom;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (rsp_valid !== 1'b1) return;
        ok = 1;
        r = rsp_rdata;
        e = rsp_err;
        stab = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== r || rsp_err !== e || req_ready !== 1'b0)
                stab = 0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
        checks++; if (leds !== 6'h0) begin errors++; $display("FAIL reset_leds got=%h want=0", leds); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        op_t ops [3] = '{
            '{32'h8000_0010, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0},
            '{32'h8000_0010, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0},
            '{32'h8000_0010, 1'b0, 2'b10, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0}
        };
        logic [31:0] r; logic e; int lat; bit stab, ok; logic [32:0] exp;
        foreach (ops[i]) begin
            do_req(ops[i], 0, r, e, lat, stab, ok);
            exp = sb.pop_front();
            checks++;
            if (!ok || {e, r} !== exp) begin
                errors++;
                $display("FAIL word[%0d] rdata=%h err=%b want rdata=%h err=%b", i, r, e, exp[31:0], exp[32]);
            end
            checks++;
            if (lat !== WAITC + 1) begin
                errors++;
                $display("FAIL word_latency[%0d] got=%0d want=%0d", i, lat, WAITC + 1);
            end
        end
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL word_return_idle rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_extend();
        op_t ops [6] = '{
            '{32'h8000_0013, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0},
            '{32'h8000_0013, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_00DE, 1'b0},
            '{32'h8000_0010, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFEF, 1'b0},
            '{32'h8000_0011, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_00BE, 1'b0},
            '{32'h8000_0010, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFF_BEEF, 1'b0},
            '{32'h8000_0012, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_DEAD, 1'b0}
        };
        logic [31:0] r; logic e; int lat; bit stab, ok; logic [32:0] exp;
        foreach (ops[i]) begin
            do_req(ops[i], 0, r, e, lat, stab, ok);
            exp = sb.pop_front();
            checks++;
            if (!ok || {e, r} !== exp) begin
                errors++;
                $display("FAIL extend[%0d] rdata=%h err=%b want rdata=%h err=%b", i, r, e, exp[31:0], exp[32]);
            end
        end
    endtask

    task automatic test_merge();
        op_t ops [4] = '{
            '{32'h8000_0011, 1'b1, 2'b00, 1'b0, 32'hFFFF_FF55, 32'h0, 1'b0},
            '{32'h8000_0010, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEAD_55EF, 1'b0},
            '{32'h8000_0012, 1'b1, 2'b01, 1'b0, 32'h1234_A5A5, 32'h0, 1'b0},
            '{32'h8000_0010, 1'b0, 2'b10, 1'b0, 32'h0, 32'hA5A5_55EF, 1'b0}
        };
        logic [31:0] r; logic e; int lat; bit stab, ok; logic [32:0] exp;
        foreach (ops[i]) begin
            do_req(ops[i], 0, r, e, lat, stab, ok);
            exp = sb.pop_front();
            checks++;
            if (!ok || {e, r} !== exp) begin
                errors++;
                $display("FAIL merge[%0d] rdata=%h err=%b want rdata=%h err=%b", i, r, e, exp[31:0], exp[32]);
            end
        end
    endtask

    task automatic test_backpressure();
        op_t op = '{32'h8000_0010, 1'b0, 2'b10, 1'b0, 32'h0, 32'hA5A5_55EF, 1'b0};
        logic [31:0] r; logic e; int lat; bit stab, ok; logic [32:0] exp;
        do_req(op, 5, r, e, lat, stab, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || {e, r} !== exp) begin
            errors++;
            $display("FAIL backpressure rdata=%h err=%b want rdata=%h err=%b", r, e, exp[31:0], exp[32]);
        end
        checks++;
        if (stab !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_stable got=%b want=1", stab);
        end
    endtask

    task automatic test_reset_wait();
        op_t op = '{32'h8000_0010, 1'b0, 2'b10, 1'b0, 32'h0, 32'hA5A5_55EF, 1'b0};
        logic [31:0] r; logic e; int lat; bit stab, ok; logic [32:0] exp;
        bit seen;
        req_valid = 1'b1; req_addr = 32'h8000_0010; req_we = 1'b1;
        req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_idle req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_wait_no_rsp got=1 want=0");
        end
        do_req(op, 0, r, e, lat, stab, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok || {e, r} !== exp) begin
            errors++;
            $display("FAIL rst_wait_old_data rdata=%h err=%b want rdata=%h err=%b", r, e, exp[31:0], exp[32]);
        end
    endtask

    task automatic test_faults();
        op_t ops [10] = '{
            '{32'h8000_0000, 1'b1, 2'b10, 1'b0, 32'h1122_3344, 32'h0, 1'b0},
            '{32'h8000_0002, 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1},
            '{32'h8000_0001, 1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1},
            '{32'h8000_0000, 1'b1, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1},
            '{32'h8000_0002, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1},
            '{32'h7FFF_FFFC, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1},
            '{32'h8000_1000, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1},
            '{32'h8000_0FFC, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0},
            '{32'h8000_0FFC, 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0},
            '{32'h8000_0000, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 1'b0}
        };
        logic [31:0] r; logic e; int lat; bit stab, ok; logic [32:0] exp;
        foreach (ops[i]) begin
            do_req(ops[i], 0, r, e, lat, stab, ok);
            exp = sb.pop_front();
            checks++;
            if (!ok || {e, r} !== exp) begin
                errors++;
                $display("FAIL fault[%0d] rdata=%h err=%b want rdata=%h err=%b", i, r, e, exp[31:0], exp[32]);
            end
        end
    endtask

    task automatic test_led();
`ifdef DMEM_LED_MMIO_EN
        op_t ops [3] = '{
            '{32'h1000_0000, 1'b1, 2'b10, 1'b0, 32'h0000_002A, 32'h0, 1'b0},
            '{32'h1000_0000, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_002A, 1'b0},
            '{32'h1000_0000, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1}
        };
        logic [5:0] want_leds = 6'b101010;
`else
        op_t ops [2] = '{
            '{32'h1000_0000, 1'b1, 2'b10, 1'b0, 32'h0000_002A, 32'h0, 1'b1},
            '{32'h1000_0000, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1}
        };
        logic [5:0] want_leds = 6'h0;
`endif
        logic [31:0] r; logic e; int lat; bit stab, ok; logic [32:0] exp;
        foreach (ops[i]) begin
            do_req(ops[i], 0, r, e, lat, stab, ok);
            exp = sb.pop_front();
            checks++;
            if (!ok || {e, r} !== exp) begin
                errors++;
                $display("FAIL led[%0d] rdata=%h err=%b want rdata=%h err=%b", i, r, e, exp[31:0], exp[32]);
            end
            checks++;
            if (leds !== want_leds) begin
                errors++;
                $display("FAIL led_reg[%0d] got=%b want=%b", i, leds, want_leds);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word();
        test_extend();
        test_merge();
        test_backpressure();
        test_reset_wait();
        test_faults();
        test_led();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the core's load/store port. It accepts one request at a time over a valid/ready handshake and performs byte, half or word reads and writes on an internal word-organised RAM. It returns the read data, sign- or zero-extended, over a second valid/ready handshake after a programmable number of wait states. It sits between the core's data-access initiator and on-chip storage, and replaces the zero-latency simulation memory once the core is handshake-aware.

Parameters:
ADDR_BASE, 32'h80000000, byte address of RAM word 0
DEPTH_WORDS, 1024, RAM depth in 32-bit words (power of two)
WAIT_CYCLES, 1, wait states inserted between request accept and response (0..15)
LED_ADDR, 32'h10000000, word address of the LED register (used only with the optional feature)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_addr  input  32  byte address
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  response present
rsp_ready  input  1  initiator accepts the response
rsp_rdata  output  32  load result; 0 for stores and errors
rsp_err  output  1  access fault on this response
leds  output  6  LED register; constant 0 when the optional feature is absent

Behaviour:
- Reset (rst high at a clk edge) forces the following, regardless of the current state:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, leds = 0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On req_valid & req_ready, latch addr, we, size, unsigned and wdata. Go to WAIT if WAIT_CYCLES > 0 (counter loaded with WAIT_CYCLES - 1); otherwise go to RESP.
  - WAIT: req_ready = 0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: req_ready = 0, rsp_valid = 1. rsp_rdata and rsp_err stay stable until rsp_ready; on rsp_valid & rsp_ready, go to IDLE.
- Access timing:
  - The access executes on the edge that enters RESP: the RAM write commits and the read data is registered there.
  - Latency from the accept edge to rsp_valid high is WAIT_CYCLES + 1 cycles.
  - There is no request pipelining. The next accept happens no earlier than the cycle after the response handshake.
- Offset and fault rules:
  - offset = req_addr - ADDR_BASE, computed as 32-bit unsigned with wrap, so addresses below ADDR_BASE fault.
  - Fault if any of: size = 11; half with addr[0] != 0; word with addr[1:0] != 0; offset >= DEPTH_WORDS*4.
  - On fault: rsp_err = 1, rsp_rdata = 0, no RAM or LED write.
- Little-endian lanes:
  - byte lane = offset[1:0]; half lane = offset[1].
  - Stores merge only the addressed lanes; untouched bytes are preserved.
  - Loads extract the addressed lanes, then extend per req_unsigned. The word size ignores req_unsigned.
- Reset mid-operation:
  - Reset in WAIT: no write is committed and no response is produced.
  - Reset in RESP: the response is dropped.
- Inputs are sampled only at accept; changes to them during WAIT or RESP have no effect.

Optional Feature:
DMEM_LED_MMIO_EN
- Defined: a word store with req_addr == LED_ADDR writes req_wdata[5:0] to leds. A word load at LED_ADDR returns {26'b0, leds}. Non-word accesses to LED_ADDR fault. The LED register is exempt from the range check.
- Undefined: LED_ADDR is an ordinary address (faults unless it falls in the RAM range), and leds is tied to 0.

Test Plan:
- Word store then load, WAIT_CYCLES=1, rsp_ready held 1:
  - store 32'hDEADBEEF at 32'h80000010 -> rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0.
  - load of the same address -> 32'hDEADBEEF.
- Byte and half extension, word 32'h80000010 = 32'hDEADBEEF:
  - signed byte at 32'h80000013 -> 32'hFFFFFFDE; unsigned byte -> 32'h000000DE.
  - signed half at 32'h80000010 -> 32'hFFFFBEEF.
- Partial store merge: byte store 8'h55 at 32'h80000011 over 32'hDEADBEEF -> word load returns 32'hDEAD55EF.
- Faults, each giving rsp_err=1, rsp_rdata=0 and memory unchanged:
  - word at 32'h80000002; half at 32'h80000001; size=11; any access at 32'h7FFFFFFC; any access at ADDR_BASE + 4096.
- Backpressure and reset:
  - rsp_ready low for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout.
  - rst pulsed during WAIT of a store -> no response, req_ready=1 next cycle, and a later load reads the old data.
- With DMEM_LED_MMIO_EN: word store 32'h0000002A at 32'h10000000 -> leds = 6'b101010; word load there returns 32'h0000002A.
